// File: rtl/edge_det_multi.sv
// Per-channel async-input synchroniser, persistence debounce and edge pulse with sticky flag.
// Latency SYNC_STAGES+FILT_LEN edges from a clean step to level/out; no backpressure, every qualifying edge pulses.
module edge_det_multi #(
  parameter int          N           = 4,
  parameter logic [N-1:0] INIT       = '0,
  parameter int          MODE        = 0,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 1,
  localparam int         CW          = $clog2(FILT_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [N-1:0] clr,
  output logic [N-1:0] level,
  output logic [N-1:0] out,
  output logic [N-1:0] sticky
);

  localparam bit RISE = (MODE == 0) || (MODE == 2);
  localparam bit FALL = (MODE == 1) || (MODE == 2);

  if (!(MODE inside {0, 1, 2})) begin : g_bad_mode
    $error("edge_det_multi: MODE must be 0, 1 or 2");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("edge_det_multi: SYNC_STAGES must be 0..3");
  end
  if (FILT_LEN < 1 || N < 1) begin : g_bad_len
    $error("edge_det_multi: FILT_LEN and N must be >= 1");
  end

  logic [N-1:0]  s;
  logic [N-1:0]  chg;
  logic [N-1:0]  hit;
  logic [CW-1:0] cnt [N];

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [N-1:0] sq [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) sq[k] <= INIT;
      end else begin
        sq[0] <= in;
        for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
      end
    end

    assign s = sq[SYNC_STAGES-1];
  end

  // The level flips only once the mismatch has persisted for FILT_LEN consecutive edges.
  always_comb begin
    chg = '0;
    hit = '0;
    for (int i = 0; i < N; i++) begin
      chg[i] = (s[i] != level[i]) && (cnt[i] == CW'(FILT_LEN - 1));
      hit[i] = chg[i] && ((RISE && s[i]) || (FALL && !s[i]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= INIT;
      out    <= '0;
      sticky <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      level  <= level ^ chg;
      out    <= hit;
      // A new event takes priority over a clear in the same cycle.
      sticky <= hit | (sticky & ~clr);
      for (int i = 0; i < N; i++) begin
        if ((s[i] == level[i]) || chg[i]) cnt[i] <= '0;
        else                              cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_det_multi.sv
// Directed bench for edge_det_multi: four instances cover rising/falling/both, debounce, sticky and reset.
module tb_edge_det_multi;

  logic       clk;
  logic       rst;
  logic [3:0] in_a, clr_a, level_a, out_a, sticky_a;
  logic [3:0] in_b, clr_b, level_b, out_b, sticky_b;
  logic [3:0] in_c, clr_c, level_c, out_c, sticky_c;
  logic [3:0] in_d, clr_d, level_d, out_d, sticky_d;

  int checks = 0;
  int errors = 0;

  edge_det_multi #(.N(4), .INIT(4'h0), .MODE(0), .SYNC_STAGES(2), .FILT_LEN(1)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .clr(clr_a), .level(level_a), .out(out_a), .sticky(sticky_a));
  edge_det_multi #(.N(4), .INIT(4'h0), .MODE(2), .SYNC_STAGES(0), .FILT_LEN(3)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .clr(clr_b), .level(level_b), .out(out_b), .sticky(sticky_b));
  edge_det_multi #(.N(4), .INIT(4'hF), .MODE(1), .SYNC_STAGES(2), .FILT_LEN(1)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .clr(clr_c), .level(level_c), .out(out_c), .sticky(sticky_c));
  edge_det_multi #(.N(4), .INIT(4'h0), .MODE(0), .SYNC_STAGES(2), .FILT_LEN(4)) u_d (
    .clk(clk), .rst(rst), .in(in_d), .clr(clr_d), .level(level_d), .out(out_d), .sticky(sticky_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; returns on the following falling edge where outputs are sampled.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b0;
    in_a = 4'h0; clr_a = 4'h0;
    in_b = 4'h0; clr_b = 4'h0;
    in_c = 4'hF; clr_c = 4'h0;
    in_d = 4'h0; clr_d = 4'h0;
    step(2);
    chk("a_rst_level", level_a, 4'h0);
    chk("a_rst_out", out_a, 4'h0);
    chk("a_rst_sticky", sticky_a, 4'h0);
    chk("c_rst_level", level_c, 4'hF);
    chk("c_rst_out", out_c, 4'h0);
    rst = 1'b1;
    step(1);
    chk("c_release_out", out_c, 4'h0);

    // A: rising, two sync stages, no debounce
    in_a = 4'b0001;
    step(1); chk("a_e1_out", out_a, 4'h0);
    step(1); chk("a_e2_out", out_a, 4'h0);
    step(1); chk("a_e3_out", out_a, 4'b0001);
    chk("a_e3_level", level_a, 4'b0001);
    chk("a_e3_sticky", sticky_a, 4'b0001);
    step(1); chk("a_e4_out", out_a, 4'h0);
    in_a = 4'h0;
    step(2); chk("a_fall_e2_level", level_a, 4'b0001);
    chk("a_fall_e2_out", out_a, 4'h0);
    step(1); chk("a_fall_e3_level", level_a, 4'h0);
    chk("a_fall_e3_out", out_a, 4'h0);
    step(1); chk("a_fall_sticky_hold", sticky_a, 4'b0001);
    clr_a = 4'hF;
    step(1); chk("a_clr_sticky", sticky_a, 4'h0);
    clr_a = 4'h0;

    // A: sticky set wins over simultaneous clear
    in_a = 4'b1000;
    step(3); chk("a_ch3_out", out_a, 4'b1000);
    chk("a_ch3_sticky", sticky_a, 4'b1000);
    in_a = 4'h0;
    step(3); chk("a_ch3_fall_level", level_a, 4'h0);
    chk("a_ch3_fall_sticky", sticky_a, 4'b1000);
    in_a = 4'b1000;
    step(2);
    clr_a = 4'b1000;
    step(1); chk("a_setwins_out", out_a, 4'b1000);
    chk("a_setwins_sticky", sticky_a, 4'b1000);
    step(1); chk("a_clr_alone_out", out_a, 4'h0);
    chk("a_clr_alone_sticky", sticky_a, 4'h0);
    clr_a = 4'h0;

    // A: all channels together
    in_a = 4'h0;
    step(3); chk("a_all_pre_level", level_a, 4'h0);
    in_a = 4'hF;
    step(2); chk("a_all_e2_out", out_a, 4'h0);
    step(1); chk("a_all_e3_out", out_a, 4'hF);
    chk("a_all_e3_sticky", sticky_a, 4'hF);
    chk("a_all_e3_level", level_a, 4'hF);
    step(1); chk("a_all_e4_out", out_a, 4'h0);
    chk("a_all_e4_sticky", sticky_a, 4'hF);

    // B: both edges, FILT_LEN=3, no sync; short glitches never accumulate
    in_b = 4'b0010;
    step(1); chk("b_g1_out", out_b, 4'h0);
    step(1); chk("b_g2_out", out_b, 4'h0);
    in_b = 4'h0;
    step(1); chk("b_g3_level", level_b, 4'h0);
    in_b = 4'b0010;
    step(1); chk("b_g4_out", out_b, 4'h0);
    step(1); chk("b_g5_out", out_b, 4'h0);
    chk("b_g5_level", level_b, 4'h0);
    in_b = 4'h0;
    step(1); chk("b_g6_level", level_b, 4'h0);
    chk("b_g6_out", out_b, 4'h0);
    in_b = 4'b0010;
    step(2); chk("b_r2_out", out_b, 4'h0);
    chk("b_r2_level", level_b, 4'h0);
    step(1); chk("b_r3_out", out_b, 4'b0010);
    chk("b_r3_level", level_b, 4'b0010);
    in_b = 4'h0;
    step(1); chk("b_f1_out", out_b, 4'h0);
    step(1); chk("b_f2_out", out_b, 4'h0);
    chk("b_f2_level", level_b, 4'b0010);
    step(1); chk("b_f3_out", out_b, 4'b0010);
    chk("b_f3_level", level_b, 4'h0);
    step(1); chk("b_f4_out", out_b, 4'h0);

    // C: falling only, INIT all ones
    in_c = 4'b1011;
    step(2); chk("c_e2_out", out_c, 4'h0);
    chk("c_e2_level", level_c, 4'hF);
    step(1); chk("c_e3_out", out_c, 4'b0100);
    chk("c_e3_level", level_c, 4'b1011);
    step(1); chk("c_e4_out", out_c, 4'h0);
    chk("c_e4_sticky", sticky_c, 4'b0100);
    in_c = 4'hF;
    step(3); chk("c_rise_level", level_c, 4'hF);
    chk("c_rise_out", out_c, 4'h0);
    step(1); chk("c_rise_out2", out_c, 4'h0);

    // D: FILT_LEN=4, async reset mid-count
    in_d = 4'b0001;
    step(5); chk("d_e5_out", out_d, 4'h0);
    chk("d_e5_level", level_d, 4'h0);
    step(1); chk("d_e6_out", out_d, 4'b0001);
    chk("d_e6_level", level_d, 4'b0001);
    chk("d_e6_sticky", sticky_d, 4'b0001);
    in_d = 4'h0;
    step(4); chk("d_midcount_level", level_d, 4'b0001);
    #2 rst = 1'b0;
    in_d = 4'b0001;
    #1;
    chk("d_async_level", level_d, 4'h0);
    chk("d_async_out", out_d, 4'h0);
    chk("d_async_sticky", sticky_d, 4'h0);
    chk("a_async_sticky", sticky_a, 4'h0);
    chk("c_async_level", level_c, 4'hF);
    @(negedge clk);
    step(1); chk("d_inrst_level", level_d, 4'h0);
    rst = 1'b1;
    step(1); chk("d_rel1_out", out_d, 4'h0);
    step(4); chk("d_rel5_out", out_d, 4'h0);
    chk("d_rel5_level", level_d, 4'h0);
    step(1); chk("d_rel6_out", out_d, 4'b0001);
    chk("d_rel6_level", level_d, 4'b0001);
    step(1); chk("d_rel7_out", out_d, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input, debounces it with a per-channel persistence counter, and emits a one-cycle registered pulse on a qualifying edge (rising, falling or both). Each channel also keeps a sticky flag that software or an FSM clears. It sits at the boundary between external/async stimulus and the synchronous event logic of the generated model.

Parameters:
N, 4, number of independent channels (>=1)
INIT, 0, N-bit reset value of synchroniser and filtered level, per channel
MODE, 0, edge select for all channels: 0 = rising, 1 = falling, 2 = both; other values are illegal and must cause an elaboration error
SYNC_STAGES, 2, flops in the input synchroniser (0..3; 0 = input used directly)
FILT_LEN, 1, consecutive cycles the synchronised input must differ from the filtered level before the level changes (>=1; 1 = no debounce)
CW, $clog2(FILT_LEN+1), counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted; deassertion synchronous to clk by system)
in  input  N  raw channel inputs, may be asynchronous
clr  input  N  per-channel sticky clear, synchronous
level  output  N  registered debounced level
out  output  N  registered one-cycle edge pulse
sticky  output  N  registered sticky edge flag

Behaviour:
- Reset (rst=0, asynchronous): sync flops = INIT, level = INIT, counters = 0, out = 0, sticky = 0. Reset asserted mid-operation aborts any count in progress; no pulse is generated by reset release even if in != INIT. A subsequent edge is detected through the normal filter path.
- Synchroniser: s[i] = in[i] delayed SYNC_STAGES cycles. With SYNC_STAGES=0, s = in.
- Filter, per channel, each clk edge:
  - s == level: cnt <= 0.
  - s != level and cnt == FILT_LEN-1: level <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than FILT_LEN cycles (after sync) never changes level. The counter restarts on any return to level; it does not accumulate across glitches.
- Edge pulse: out[i] <= 1 on the same clk edge that level[i] changes, when the direction matches MODE (0->1 for rising, 1->0 for falling, either for both). Otherwise out[i] <= 0. out is therefore never high more than one consecutive cycle per level change.
- Latency: a clean step on in, set up before edge 1, raises out after edge SYNC_STAGES+FILT_LEN and drops it one edge later. level changes on the same edge.
- Sticky: sticky[i] <= 1 when the next out[i] = 1. Otherwise sticky[i] <= 0 if clr[i] = 1, else it holds. Simultaneous edge and clr: set wins, so no event is lost.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.
- Counter never exceeds FILT_LEN-1; no wrap-around is possible.

Test Plan:
- N=4, MODE=0, SYNC_STAGES=2, FILT_LEN=1, INIT=0; drive in=4'b0001 before edge 1 -> out=4'b0001 only after edge 3; level[0]=1 from edge 3; sticky[0]=1 from edge 3. Hold in, then drive in=0 -> no out pulse.
- MODE=2, FILT_LEN=3, SYNC_STAGES=0; in[1] high 2 cycles then low -> level and out never change. in[1] high 3 cycles -> out[1] pulses after edge 3. in[1] then falls and stays low -> second pulse 3 edges later.
- MODE=1, INIT=4'hF; release reset with in=4'hF, then in[2]=0 -> out=4'b0100 pulse after the latency. Raising in[2] back -> no pulse.
- Sticky: set sticky[3] by an edge, assert clr[3] on the same cycle as a new edge on ch3 -> sticky[3] stays 1. Assert clr[3] alone next cycle -> sticky[3]=0 the following edge.
- Assert rst=0 asynchronously mid-count (cnt=2 of FILT_LEN=4) -> level, out, sticky = INIT/0/0 immediately without a clk edge. Release with in=~INIT -> pulse only after the full SYNC_STAGES+FILT_LEN edges.
- All four channels stepped together -> out=4'hF for exactly one cycle; sticky=4'hF.
